// File: rtl/bpred_sdp_ram.sv
// bpred_sdp_ram: simple-dual-port synchronous RAM with one write port and a
// registered read port. After reset deasserts, an initialization sweep
// writes INIT_VAL to every word. The RAM is used by the return-address
// stack, the instruction memory and the bimodal direction table.
//
// Handshake: this block has no valid/ready interface.
//   - Both ports are always available once init_busy is low.
//   - While init_busy is high, wren is ignored and the write is dropped.
//   - Read data appears on q one rising edge after rdaddress is presented.
//   - If the read and the write hit the same address on the same edge,
//     q returns the old contents.
module bpred_sdp_ram #(
   parameter int                DATA_W   = 32,
   parameter int                ADDR_W   = 8,
   parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] rdaddress,
   output logic [DATA_W-1:0] q,
   input  logic [ADDR_W-1:0] wraddress,
   input  logic [DATA_W-1:0] data,
   input  logic              wren,
   output logic              init_busy
);

   localparam int DEPTH = 1 << ADDR_W;

   // Two-state FSM. The state is visible externally through init_busy.
   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]        r_state;
   logic [ADDR_W-1:0] r_sweep_cnt;
   logic [DATA_W-1:0] r_q;
   logic [DATA_W-1:0] r_mem [0:DEPTH-1];

   logic              w_we;
   logic [ADDR_W-1:0] w_waddr;
   logic [DATA_W-1:0] w_wdata;
   logic              w_sweep_last;

   assign w_sweep_last = (r_sweep_cnt == {ADDR_W{1'b1}});

   // Select the single array write source: the sweep in INIT, the user port in RUN.
   always_comb begin
      w_we    = 1'b0;
      w_waddr = wraddress;
      w_wdata = data;
      if (r_state == ST_INIT) begin
         w_we    = 1'b1;
         w_waddr = r_sweep_cnt;
         w_wdata = INIT_VAL;
      end else if (wren) begin
         w_we    = 1'b1;
      end
   end

   // FSM and sweep counter. Reset restarts the sweep from address 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_INIT;
         r_sweep_cnt <= '0;
      end else if (r_state == ST_INIT) begin
         r_sweep_cnt <= r_sweep_cnt + 1'b1;
         if (w_sweep_last) begin
            r_state <= ST_RUN;
         end
      end
   end

   // Array write port. The array is not reset, and no write happens while reset is held.
   always_ff @(posedge clk) begin
      if (!reset && w_we) begin
         r_mem[w_waddr] <= w_wdata;
      end
   end

   // Registered read. This reads the pre-edge contents, which gives old-data behaviour on a same-address write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_q <= '0;
      end else if (r_state == ST_INIT) begin
         r_q <= INIT_VAL;
      end else begin
         r_q <= r_mem[rdaddress];
      end
   end

   assign q         = r_q;
   assign init_busy = (r_state == ST_INIT);

endmodule

// File: tb/tb_bpred_sdp_ram.sv
// Directed testbench for bpred_sdp_ram. It uses three configurations:
//   u_a: 16x32 with INIT_VAL A5A5A5A5. Covers reset, the sweep, dropped
//        init writes and reset in the middle of a sweep.
//   u_b: 256x32 with INIT_VAL 0. Covers basic write/read and
//        read-during-write.
//   u_c: 4096x2 with INIT_VAL 0. Covers the narrow configuration at the
//        address extremes.
module tb_bpred_sdp_ram;

   // clock / reset
   logic clk;
   logic reset;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   localparam logic [31:0] IV_A = 32'hA5A5A5A5;

   logic [3:0]  rd_a, wr_a;
   logic [31:0] d_a, q_a;
   logic        we_a, busy_a;

   logic [7:0]  rd_b, wr_b;
   logic [31:0] d_b, q_b;
   logic        we_b, busy_b;

   logic [11:0] rd_c, wr_c;
   logic [1:0]  d_c, q_c;
   logic        we_c, busy_c;

   bpred_sdp_ram #(.DATA_W(32), .ADDR_W(4), .INIT_VAL(IV_A)) u_a (
      .clk(clk), .reset(reset), .rdaddress(rd_a), .q(q_a),
      .wraddress(wr_a), .data(d_a), .wren(we_a), .init_busy(busy_a)
   );

   bpred_sdp_ram #(.DATA_W(32), .ADDR_W(8), .INIT_VAL(32'h0)) u_b (
      .clk(clk), .reset(reset), .rdaddress(rd_b), .q(q_b),
      .wraddress(wr_b), .data(d_b), .wren(we_b), .init_busy(busy_b)
   );

   bpred_sdp_ram #(.DATA_W(2), .ADDR_W(12), .INIT_VAL(2'b00)) u_c (
      .clk(clk), .reset(reset), .rdaddress(rd_c), .q(q_c),
      .wraddress(wr_c), .data(d_c), .wren(we_c), .init_busy(busy_c)
   );

   int checks = 0;
   int errors = 0;

   // driver helper: advance one rising edge and settle 1 time unit past it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // checker helper
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      int n;
      reset = 1'b1;
      rd_a = '0; wr_a = '0; d_a = '0; we_a = 1'b0;
      rd_b = '0; wr_b = '0; d_b = '0; we_b = 1'b0;
      rd_c = '0; wr_c = '0; d_c = '0; we_c = 1'b0;

      // first release; the sweep drives q to INIT_VAL
      tick(); tick();
      #2 reset = 1'b0;
      tick(); tick(); tick();
      chk("q_during_sweep", q_a, IV_A);
      chk("busy_during_sweep", {31'd0, busy_a}, 32'd1);

      // asynchronous reset pulse in the middle of a cycle
      #2 reset = 1'b1;
      #1;
      chk("async_reset_q", q_a, 32'd0);
      chk("async_reset_busy", {31'd0, busy_a}, 32'd1);
      tick(); tick();

      // user write attempted for the whole sweep; it must be dropped
      we_a = 1'b1; wr_a = 4'd2; d_a = 32'h77;
      #2 reset = 1'b0;
      for (int i = 0; i < 15; i++) tick();
      chk("busy_after_15_edges", {31'd0, busy_a}, 32'd1);
      tick();
      chk("busy_after_16_edges", {31'd0, busy_a}, 32'd0);
      we_a = 1'b0;

      for (int i = 0; i < 16; i++) begin
         rd_a = 4'(i);
         tick();
         chk("sweep_read_a", q_a, IV_A);
      end
      rd_a = 4'd2;
      tick();
      chk("init_write_dropped", q_a, IV_A);

      // run-mode write, then restart the sweep from the middle
      we_a = 1'b1; wr_a = 4'd9; d_a = 32'h12345678;
      tick();
      we_a = 1'b0; rd_a = 4'd9;
      tick();
      chk("a_write_read", q_a, 32'h12345678);

      #2 reset = 1'b1;
      tick();
      #2 reset = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      #2 reset = 1'b1;
      #1;
      chk("midsweep_reset_q", q_a, 32'd0);
      tick();
      #2 reset = 1'b0;
      for (int i = 0; i < 15; i++) tick();
      chk("restart_busy_15", {31'd0, busy_a}, 32'd1);
      tick();
      chk("restart_busy_16", {31'd0, busy_a}, 32'd0);
      for (int i = 0; i < 16; i++) begin
         rd_a = 4'(i);
         tick();
         chk("restart_read_a", q_a, IV_A);
      end

      // wait for the longest sweep, with a bound
      n = 0;
      while (busy_c && n < 5000) begin
         tick();
         n++;
      end
      chk("sweep_c_done", {31'd0, busy_c}, 32'd0);
      chk("sweep_b_done", {31'd0, busy_b}, 32'd0);

      // u_b basic write/read
      we_b = 1'b1; wr_b = 8'h3C; d_b = 32'hDEADBEEF;
      tick();
      we_b = 1'b0; rd_b = 8'h3C;
      tick();
      chk("b_read_3c", q_b, 32'hDEADBEEF);
      rd_b = 8'h3D;
      tick();
      chk("b_read_3d_init", q_b, 32'h0);

      // read-during-write at address 5
      we_b = 1'b1; wr_b = 8'd5; d_b = 32'h11111111;
      tick();
      rd_b = 8'd5; d_b = 32'h22222222;
      tick();
      chk("rdw_old_data", q_b, 32'h11111111);
      we_b = 1'b0;
      tick();
      chk("rdw_new_data", q_b, 32'h22222222);

      // u_c narrow configuration at the address extremes
      we_c = 1'b1; wr_c = 12'hFFF; d_c = 2'b11;
      tick();
      wr_c = 12'h000; d_c = 2'b01;
      tick();
      we_c = 1'b0; rd_c = 12'hFFF;
      tick();
      chk("c_read_fff", {30'd0, q_c}, 32'd3);
      rd_c = 12'h000;
      tick();
      chk("c_read_000", {30'd0, q_c}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
